// File: rtl/npc_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC,
// the halting instruction word and the fetch FSM state encoding.
package npc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } ifu_state_t;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding word fetch, a one-entry
// buffer to the decoder, redirect with kill of in-flight responses.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   imem_req_valid/ready/addr          fetch request channel
//   imem_rsp_valid/data                fetch response (no backpressure)
//   inst_valid/ready, inst, inst_pc    decoder handshake
//   redirect_valid, redirect_pc        branch/jump target
//   halted                             set after EBREAK is consumed
module ifu
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [31:0] EBREAK_INST = npc_pkg::EBREAK_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  ifu_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        kill_q, kill_d;
  logic [31:0] redir_pc;
  logic        unused_redir_bits;

  assign redir_pc          = {redirect_pc[31:2], 2'b00};
  assign unused_redir_bits = ^redirect_pc[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    kill_d  = kill_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
          // Old address already accepted: its
          // response must be dropped.
          if (imem_req_ready) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (imem_rsp_valid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (kill_q) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            buf_d   = imem_rsp_data;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // Redirect wins over a same-cycle consume.
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d = pc_q + 32'd4;
          if (buf_q == EBREAK_INST) begin
            state_d = S_HALT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      buf_q   <= 32'd0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      kill_q  <= kill_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = buf_q;
  assign inst_pc        = pc_q;
  assign halted         = (state_q == S_HALT);

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: directed fetch, stall, redirect,
// halt and reset scenarios against a small memory responder.
module tb_ifu;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] EBRK   = 32'h0010_0073;

  int tests = 0;
  int fails = 0;
  int rsp_delay = 0;

  logic [31:0] req_q[$];
  logic [63:0] inst_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // addi x0,x0,imm with imm = word index; one EBREAK slot
  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    if (a == 32'h8000_0204) return EBRK;
    return {a[13:2], 20'h00013};
  endfunction

  // Memory responder: one response per accepted request,
  // rsp_delay extra cycles after the accepting edge.
  initial begin
    logic        fire;
    logic        pend;
    logic [31:0] a;
    logic [31:0] pa;
    int          cnt;
    pend = 1'b0;
    cnt  = 0;
    pa   = 32'd0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    forever begin
      @(negedge clk);
      fire = rst_n && imem_req_valid && imem_req_ready;
      a    = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (fire) begin
          pend = 1'b1;
          pa   = a;
          cnt  = rsp_delay;
        end
        if (pend) begin
          if (cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pa);
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Monitor: compares every request and every consumed
  // instruction against the expected queues.
  initial begin
    logic [31:0] e;
    logic [63:0] ei;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", imem_req_addr, 32'hxxxx_xxxx);
        end else begin
          e = req_q.pop_front();
          chk("req_addr", imem_req_addr, e);
        end
      end
      if (rst_n && inst_valid && inst_ready
          && !redirect_valid) begin
        if (inst_q.size() == 0) begin
          chk("inst_unexpected", inst_pc, 32'hxxxx_xxxx);
        end else begin
          ei = inst_q.pop_front();
          chk("inst_pc", inst_pc, ei[63:32]);
          chk("inst_word", inst, ei[31:0]);
        end
      end
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_inst"}, inst, 32'd0);
    chk({tag, "_inst_pc"}, inst_pc, RST_PC);
    chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
  endtask

  task automatic wait_inst(input string name,
                           input logic [31:0] pc,
                           input int maxc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (inst_valid && inst_pc == pc) begin
        found = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_req(input string name,
                          input int maxc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (imem_req_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    logic [8:0] vseq;
    int         nreq;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    repeat (2) tick();
    chk_reset_outs("rst");

    // Back-to-back fetch, zero-wait memory
    req_q.push_back(32'h8000_0000);
    req_q.push_back(32'h8000_0004);
    req_q.push_back(32'h8000_0008);
    inst_q.push_back({32'h8000_0000, 32'h0000_0013});
    inst_q.push_back({32'h8000_0004, 32'h0010_0013});
    inst_q.push_back({32'h8000_0008, 32'h0020_0013});
    inst_ready = 1'b1;
    rst_n      = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      vseq[i] = inst_valid;
    end
    chk("valid_cadence", {23'd0, vseq}, 32'h0000_0124);

    // Decoder stall in HOLD
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_inst", inst, 32'h0020_0013);
      chk("stall_pc", inst_pc, 32'h8000_0008);
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_req", {31'd0, imem_req_valid}, 32'd0);
    end
    rsp_delay = 2;
    req_q.push_back(32'h8000_000C);
    inst_ready = 1'b1;
    tick();
    chk("adv_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("adv_req_addr", imem_req_addr, 32'h8000_000C);

    // Redirect in WAIT, response arrives later
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    rsp_delay      = 0;
    req_q.push_back(32'h8000_0100);
    wait_req("wait_redir_req", 10);
    chk("redir_wait_addr", imem_req_addr, 32'h8000_0100);

    // Redirect in HOLD beats a same-cycle consume
    wait_inst("wait_0100", 32'h8000_0100, 10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    req_q.push_back(32'h8000_0200);
    tick();
    redirect_valid = 1'b0;
    chk("hold_redir_req", {31'd0, imem_req_valid}, 32'd1);
    chk("hold_redir_addr", imem_req_addr, 32'h8000_0200);
    chk("hold_redir_iv", {31'd0, inst_valid}, 32'd0);

    // EBREAK halts fetch
    inst_q.push_back({32'h8000_0200, 32'h0800_0013});
    req_q.push_back(32'h8000_0204);
    inst_q.push_back({32'h8000_0204, EBRK});
    wait_inst("wait_ebreak", 32'h8000_0204, 20);
    tick();
    chk("halted", {31'd0, halted}, 32'd1);
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      redirect_valid = (i == 3);
      redirect_pc    = 32'h8000_0000;
      tick();
      if (imem_req_valid || inst_valid) nreq++;
    end
    redirect_valid = 1'b0;
    chk("halt_quiet", nreq, 0);
    chk("halt_stays", {31'd0, halted}, 32'd1);
    chk("req_q_empty", req_q.size(), 0);
    chk("inst_q_empty", inst_q.size(), 0);

    // Redirect in REQ without ready
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("req_nordy_v", {31'd0, imem_req_valid}, 32'd1);
    chk("req_nordy_a", imem_req_addr, RST_PC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0400;
    tick();
    redirect_valid = 1'b0;
    chk("req_redir_v", {31'd0, imem_req_valid}, 32'd1);
    chk("req_redir_a", imem_req_addr, 32'h8000_0400);

    // Reset while waiting on a response
    req_q.push_back(32'h8000_0400);
    imem_req_ready = 1'b1;
    rsp_delay      = 3;
    tick();
    chk("in_wait_req", {31'd0, imem_req_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("arst");
    repeat (2) tick();
    rsp_delay = 0;
    req_q.push_back(RST_PC);
    inst_q.push_back({RST_PC, 32'h0000_0013});
    rst_n = 1'b1;
    tick();
    chk("post_rst_v", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_a", imem_req_addr, RST_PC);
    wait_inst("wait_post_rst", RST_PC, 10);
    imem_req_ready = 1'b0;
    tick();
    tick();
    chk("end_req_q", req_q.size(), 0);
    chk("end_inst_q", inst_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
